// File: rtl/alu_uart_frontend.sv
// Command front end for the EX-stage ALU: gathers operand1/operand2/opcode bytes
// from the UART receiver, latches the ALU result and returns it as two bytes, high first.
module alu_uart_frontend #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_OUT         = 16,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic [NB_DATA-1:0] o_operand1,
  output logic [NB_DATA-1:0] o_operand2,
  output logic [NB_OP-1:0]   o_opcode,
  input  logic [NB_OUT-1:0]  i_alu_result,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_OP2, WAIT_OPC, EXEC, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO
  } state_t;

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic signed [NB_OUT-1:0]  result;

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      result     <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_operand1 <= '0;
      o_operand2 <= '0;
      o_opcode   <= '0;
      o_timeout  <= 1'b0;
    end else begin
      o_tx_start <= 1'b0;
      o_timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_rx_done) begin
            o_operand1 <= i_rx_data;
            cnt        <= '0;
            state      <= WAIT_OP2;
          end
        end
        WAIT_OP2: begin
          // An arriving byte beats the terminal count in the same cycle.
          if (i_rx_done) begin
            o_operand2 <= i_rx_data;
            cnt        <= '0;
            state      <= WAIT_OPC;
          end else if (cnt == TERM_CNT) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        WAIT_OPC: begin
          if (i_rx_done) begin
            o_opcode <= i_rx_data[NB_OP-1:0];
            cnt      <= '0;
            state    <= EXEC;
          end else if (cnt == TERM_CNT) begin
            o_timeout <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        EXEC: begin
          // Operands settled for this whole cycle; the high byte launches with the capture.
          result     <= i_alu_result;
          o_tx_data  <= i_alu_result[NB_OUT-1:NB_DATA];
          o_tx_start <= 1'b1;
          state      <= SEND_HI;
        end
        SEND_HI: state <= WAIT_HI;
        WAIT_HI: begin
          if (i_tx_done) begin
            o_tx_data  <= result[NB_DATA-1:0];
            o_tx_start <= 1'b1;
            state      <= SEND_LO;
          end
        end
        SEND_LO: state <= WAIT_LO;
        WAIT_LO: begin
          if (i_tx_done) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
